// File: rtl/life_board_if.sv
// Command/status bundle between the game controller (master) and the board engine (slave).
interface life_board_if;
    logic        restart;
    logic        load_data;
    logic        data_in;
    logic        read_data;
    logic        write_out;
    logic        data_out;
    logic        data_valid;
    logic        busy;
    logic        gen_done;
    logic [14:0] gen_count;
    logic        lose_sig;

    modport master (
        output restart, load_data, data_in, read_data, write_out,
        input  data_out, data_valid, busy, gen_done, gen_count, lose_sig
    );

    modport slave (
        input  restart, load_data, data_in, read_data, write_out,
        output data_out, data_valid, busy, gen_done, gen_count, lose_sig
    );
endinterface

// File: rtl/life_board_engine.sv
// Toroidal Game-of-Life board: serial load, one-row-per-cycle generation step,
// serial dump, with generation counter and sticky lose detection.
module life_board_engine #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic         clka,
    input  logic         rst_n,
    life_board_if.slave  bus
);
    localparam int N    = ROWS * COLS;
    localparam int IDXW = $clog2(N + 1);
    localparam int ROWW = $clog2(ROWS);
    localparam int SHW  = (ROWS - 1) * COLS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] DUMP = 2'd3;

    logic [1:0]      state_r;
    logic [N-1:0]    board_r;
    logic [SHW-1:0]  shadow_r;
    logic [IDXW-1:0] idx_r;
    logic [ROWW-1:0] row_r;
    logic            prev_read_r;
    logic            prev_write_r;
    logic            data_out_r;
    logic            data_valid_r;
    logic            busy_r;
    logic            gen_done_r;
    logic [14:0]     gen_count_r;
    logic            lose_r;

    logic [ROWW-1:0] row_up_s;
    logic [ROWW-1:0] row_dn_s;
    logic [COLS-1:0] new_row_s;
    logic [N-1:0]    merged_s;
    logic            read_edge_s;
    logic            write_edge_s;
    logic            cell_s;
    logic [14:0]     gen_next_s;

    function automatic logic [COLS-1:0] row_of(input logic [N-1:0] b, input logic [ROWW-1:0] r);
        logic [COLS-1:0] res;
        res = {COLS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            res = (r == ROWW'(i)) ? b[i*COLS +: COLS] : res;
        end
        return res;
    endfunction

    function automatic logic cell_of(input logic [N-1:0] b, input logic [IDXW-1:0] k);
        logic res;
        res = 1'b0;
        for (int i = 0; i < N; i++) begin
            res = (k == IDXW'(i)) ? b[i] : res;
        end
        return res;
    endfunction

    // B3/S23 applied to one row given its vertical neighbours; columns wrap.
    function automatic logic [COLS-1:0] next_row(input logic [COLS-1:0] up,
                                                 input logic [COLS-1:0] cur,
                                                 input logic [COLS-1:0] dn);
        logic [COLS-1:0] res;
        logic [3:0]      cnt;
        int              cl;
        int              cr;
        for (int c = 0; c < COLS; c++) begin
            cl = (c == 0) ? COLS - 1 : c - 1;
            cr = (c == COLS - 1) ? 0 : c + 1;
            cnt = {3'b000, up[cl]} + {3'b000, up[c]} + {3'b000, up[cr]}
                + {3'b000, cur[cl]} + {3'b000, cur[cr]}
                + {3'b000, dn[cl]} + {3'b000, dn[c]} + {3'b000, dn[cr]};
            res[c] = (cnt == 4'd3) | (cur[c] & (cnt == 4'd2));
        end
        return res;
    endfunction

    assign row_up_s     = (row_r == ROWW'(0)) ? ROWW'(ROWS - 1) : row_r - ROWW'(1);
    assign row_dn_s     = (row_r == ROWW'(ROWS - 1)) ? ROWW'(0) : row_r + ROWW'(1);
    assign new_row_s    = next_row(row_of(board_r, row_up_s), row_of(board_r, row_r),
                                   row_of(board_r, row_dn_s));
    assign merged_s     = {new_row_s, shadow_r};
    assign read_edge_s  = bus.read_data & ~prev_read_r;
    assign write_edge_s = bus.write_out & ~prev_write_r;
    assign cell_s       = cell_of(board_r, idx_r);
    assign gen_next_s   = (gen_count_r == 15'h7FFF) ? gen_count_r : gen_count_r + 15'd1;

    // Edge-detect history, sampled every cycle regardless of state or restart.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            prev_read_r  <= 1'b0;
            prev_write_r <= 1'b0;
        end else begin
            prev_read_r  <= bus.read_data;
            prev_write_r <= bus.write_out;
        end
    end

    // Main state machine, board storage and registered status outputs.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            board_r      <= {N{1'b0}};
            shadow_r     <= {SHW{1'b0}};
            idx_r        <= {IDXW{1'b0}};
            row_r        <= {ROWW{1'b0}};
            data_out_r   <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            gen_done_r   <= 1'b0;
            gen_count_r  <= 15'd0;
            lose_r       <= 1'b0;
        end else if (bus.restart) begin
            state_r      <= IDLE;
            board_r      <= {N{1'b0}};
            shadow_r     <= {SHW{1'b0}};
            idx_r        <= {IDXW{1'b0}};
            row_r        <= {ROWW{1'b0}};
            data_out_r   <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            gen_done_r   <= 1'b0;
            gen_count_r  <= 15'd0;
            lose_r       <= 1'b0;
        end else begin
            gen_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.load_data) begin
                        board_r[0] <= bus.data_in;
                        lose_r     <= 1'b0;
                        if (N > 1) begin
                            idx_r   <= IDXW'(1);
                            state_r <= LOAD;
                            busy_r  <= 1'b1;
                        end else begin
                            idx_r   <= {IDXW{1'b0}};
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (read_edge_s) begin
                        row_r   <= {ROWW{1'b0}};
                        state_r <= STEP;
                        busy_r  <= 1'b1;
                    end else if (write_edge_s) begin
                        // Cell 0 goes out on entry so cell k lands k cycles later.
                        data_out_r   <= board_r[0];
                        data_valid_r <= 1'b1;
                        idx_r        <= IDXW'(1);
                        state_r      <= DUMP;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.load_data) begin
                        for (int i = 0; i < N; i++) begin
                            if (idx_r == IDXW'(i)) begin
                                board_r[i] <= bus.data_in;
                            end
                        end
                        if (idx_r == IDXW'(N - 1)) begin
                            idx_r   <= {IDXW{1'b0}};
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            idx_r <= idx_r + IDXW'(1);
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                STEP: begin
                    for (int i = 0; i < ROWS - 1; i++) begin
                        if (row_r == ROWW'(i)) begin
                            shadow_r[i*COLS +: COLS] <= new_row_s;
                        end
                    end
                    if (row_r == ROWW'(ROWS - 1)) begin
                        board_r     <= merged_s;
                        gen_done_r  <= 1'b1;
                        gen_count_r <= gen_next_s;
                        lose_r      <= lose_r | (merged_s == {N{1'b0}}) | (merged_s == board_r);
                        row_r       <= {ROWW{1'b0}};
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end else begin
                        row_r <= row_r + ROWW'(1);
                    end
                end
                DUMP: begin
                    if (idx_r == IDXW'(N)) begin
                        data_out_r   <= 1'b0;
                        data_valid_r <= 1'b0;
                        idx_r        <= {IDXW{1'b0}};
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                    end else begin
                        data_out_r <= cell_s;
                        idx_r      <= idx_r + IDXW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.busy       = busy_r;
    assign bus.gen_done   = gen_done_r;
    assign bus.gen_count  = gen_count_r;
    assign bus.lose_sig   = lose_r;
endmodule

// File: tb/tb_life_board_engine.sv
// Randomized and directed bench for life_board_engine against a cell-array Life model.
module tb_life_board_engine;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic clka;
    logic rst_n;
    life_board_if bus ();

    life_board_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] mdl;
    int          mgen;
    logic        mlose;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Reference: plain toroidal neighbour count over the whole board.
    function automatic logic [63:0] life_next(input logic [63:0] b);
        logic [63:0] nx;
        int n;
        nx = 64'd0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0)
                            n += int'(b[((r + dr + ROWS) % ROWS) * COLS + (c + dc + COLS) % COLS]);
                    end
                end
                nx[r*COLS + c] = (n == 3) || (b[r*COLS + c] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic void model_step();
        logic [63:0] nx;
        nx = life_next(mdl);
        mlose = mlose | (nx == 64'd0) | (nx == mdl);
        mdl = nx;
        if (mgen < 32767) mgen++;
    endfunction

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        mdl = 64'd0; mgen = 0; mlose = 1'b0;
        check("restart_busy", bus.busy, 1'b0);
        check("restart_gen", bus.gen_count, 15'd0);
        check("restart_lose", bus.lose_sig, 1'b0);
    endtask

    task automatic load_board(input logic [63:0] b, input bit gaps);
        for (int k = 0; k < N; k++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.load_data = 1'b0;
                bus.data_in   = 1'($urandom);
                tick();
            end
            bus.load_data = 1'b1;
            bus.data_in   = b[k];
            tick();
            if (k == 10) check("load_busy_mid", bus.busy, 1'b1);
        end
        bus.load_data = 1'b0;
        bus.data_in   = 1'b0;
        check("load_busy_end", bus.busy, 1'b0);
        mdl = b;
        mlose = 1'b0;
    endtask

    task automatic do_step(input int hold_cycles);
        int nb;
        int ge;
        nb = 0; ge = 0;
        bus.read_data = 1'b1;
        tick();
        if (hold_cycles == 0) bus.read_data = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            nb += int'(bus.busy);
            ge += int'(bus.gen_done);
            tick();
        end
        check("step_busy_cycles", nb, ROWS);
        check("step_early_done", ge, 0);
        check("step_done_pulse", bus.gen_done, 1'b1);
        check("step_idle", bus.busy, 1'b0);
        ge = 0;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            ge += int'(bus.gen_done);
        end
        bus.read_data = 1'b0;
        if (hold_cycles > 0) check("hold_extra_done", ge, 0);
        tick();
        model_step();
        check("step_gen_count", bus.gen_count, 15'(mgen));
        check("step_lose", bus.lose_sig, mlose);
    endtask

    task automatic dump_check(input string tag);
        logic [63:0] obs;
        int nv;
        obs = 64'd0; nv = 0;
        bus.write_out = 1'b1;
        tick();
        bus.write_out = 1'b0;
        for (int k = 0; k < N; k++) begin
            obs[k] = bus.data_out;
            nv += int'(bus.data_valid);
            tick();
        end
        check({tag, "_bits"}, obs, mdl);
        check({tag, "_valid_cnt"}, nv, N);
        check({tag, "_valid_end"}, bus.data_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] b;
        int nv;
        int ge;
        rst_n = 1'b0;
        bus.restart = 1'b0; bus.load_data = 1'b0; bus.data_in = 1'b0;
        bus.read_data = 1'b0; bus.write_out = 1'b0;
        mdl = 64'd0; mgen = 0; mlose = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_data_out", bus.data_out, 1'b0);
        check("rst_gen_done", bus.gen_done, 1'b0);
        check("rst_gen_count", bus.gen_count, 15'd0);
        check("rst_lose", bus.lose_sig, 1'b0);
        dump_check("rst_dump");

        // Blinker: horizontal bar on row 3 flips vertical through col 3.
        b = 64'd0; b[26] = 1'b1; b[27] = 1'b1; b[28] = 1'b1;
        load_board(b, 1'b0);
        do_step(0);
        b = 64'd0; b[19] = 1'b1; b[27] = 1'b1; b[35] = 1'b1;
        check("blinker_model", mdl, b);
        dump_check("blinker_dump");
        check("blinker_gen", bus.gen_count, 15'd1);
        check("blinker_lose", bus.lose_sig, 1'b0);

        // Still life block.
        do_restart();
        b = 64'd0; b[9] = 1'b1; b[10] = 1'b1; b[17] = 1'b1; b[18] = 1'b1;
        load_board(b, 1'b0);
        do_step(0);
        check("block_lose", bus.lose_sig, 1'b1);
        do_step(0);
        check("block_lose_held", bus.lose_sig, 1'b1);
        check("block_model", mdl, b);
        dump_check("block_dump");

        // Extinction of a single cell.
        do_restart();
        b = 64'd1;
        load_board(b, 1'b0);
        do_step(0);
        check("ext_lose", bus.lose_sig, 1'b1);
        check("ext_model", mdl, 64'd0);
        dump_check("ext_dump");

        // Glider across both wrap edges.
        do_restart();
        b = 64'd0; b[55] = 1'b1; b[56] = 1'b1; b[6] = 1'b1; b[7] = 1'b1; b[0] = 1'b1;
        load_board(b, 1'b0);
        for (int s = 0; s < 4; s++) do_step(0);
        b = 64'd0; b[56] = 1'b1; b[1] = 1'b1; b[15] = 1'b1; b[8] = 1'b1; b[9] = 1'b1;
        check("glider_model", mdl, b);
        dump_check("glider_dump");
        check("glider_gen", bus.gen_count, 15'd4);
        check("glider_lose", bus.lose_sig, 1'b0);

        // Abort mid-dump.
        do_step(0);
        bus.write_out = 1'b1;
        tick();
        bus.write_out = 1'b0;
        repeat (20) tick();
        check("abort_valid_before", bus.data_valid, 1'b1);
        do_restart();
        check("abort_valid", bus.data_valid, 1'b0);
        dump_check("abort_dump");

        // read_data held high: one generation only.
        b = {$urandom, $urandom};
        load_board(b, 1'b1);
        dump_check("gap_load_dump");
        do_step(31);

        // write_out edge during STEP is dropped.
        nv = 0; ge = 0;
        bus.read_data = 1'b1;
        tick();
        bus.read_data = 1'b0;
        tick(); tick();
        bus.write_out = 1'b1;
        tick();
        bus.write_out = 1'b0;
        for (int i = 0; i < ROWS + 6; i++) begin
            nv += int'(bus.data_valid);
            ge += int'(bus.gen_done);
            tick();
        end
        model_step();
        check("step_wr_valid", nv, 0);
        check("step_wr_done", ge, 1);
        dump_check("step_wr_dump");

        // Randomized boards with gapped loads and random step counts.
        for (int t = 0; t < 3; t++) begin
            load_board({$urandom, $urandom}, 1'b1);
            for (int s = 0; s < int'($urandom_range(1, 3)); s++) do_step(0);
            dump_check("rand_dump");
        end

        // Asynchronous reset mid-dump, away from the clock edge.
        bus.write_out = 1'b1;
        tick();
        bus.write_out = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", bus.data_valid, 1'b0);
        check("async_gen", bus.gen_count, 15'd0);
        check("async_busy", bus.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        mdl = 64'd0; mgen = 0; mlose = 1'b0;
        tick();
        dump_check("async_dump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
